// File: rtl/tank_pkg.sv
// Shared types for the tank game datapath: Q11.4 fixed point, bullet slot record,
// playfield bounds and the bullet-pool FSM states.
package tank_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned FIX_W   = 16;
    localparam int unsigned FRAC_W  = 4;
    localparam int unsigned AGE_W   = 9;

    localparam int unsigned X_MIN = 0;
    localparam int unsigned X_MAX = 639;
    localparam int unsigned Y_MIN = 0;
    localparam int unsigned Y_MAX = 479;

    typedef logic signed [FIX_W-1:0] q11_4_t;

    typedef struct packed {
        q11_4_t           x;
        q11_4_t           y;
        q11_4_t           vx;
        q11_4_t           vy;
        logic [AGE_W-1:0] age;
        logic             active;
    } bullet_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bullet_step.sv
// One frame of motion for a single bullet slot: move, edge handling, ageing, target test.
// Edge handling selected by BULLET_BOUNCE_EN (bounce when defined, expire when undefined).
module bullet_step
    import tank_pkg::*;
#(
    parameter int unsigned LIFE_FRAMES = 300
) (
    input  bullet_slot_t       slot,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    input  logic [COORD_W-1:0] target_size,
    output bullet_slot_t       next,
    output logic               hit
);

    q11_4_t                         nx;
    q11_4_t                         ny;
    logic signed [FIX_W-FRAC_W-1:0] nx_int;
    logic signed [FIX_W-FRAC_W-1:0] ny_int;
    logic                           x_oob;
    logic                           y_oob;
    logic [FIX_W-FRAC_W:0]          dx;
    logic [FIX_W-FRAC_W:0]          dy;
    logic [FIX_W-FRAC_W:0]          adx;
    logic [FIX_W-FRAC_W:0]          ady;

    always_comb begin : step
        nx     = slot.x + slot.vx;
        ny     = slot.y + slot.vy;
        nx_int = nx[FIX_W-1:FRAC_W];
        ny_int = ny[FIX_W-1:FRAC_W];
        x_oob  = (nx_int < $signed({2'b00, x_min})) || (nx_int > $signed({2'b00, x_max}));
        y_oob  = (ny_int < $signed({2'b00, y_min})) || (ny_int > $signed({2'b00, y_max}));
        next   = slot;
        hit    = 1'b0;
        dx     = '0;
        dy     = '0;
        adx    = '0;
        ady    = '0;
        if (slot.active) begin
`ifdef BULLET_BOUNCE_EN
            if (x_oob) next.vx = -slot.vx;
            else       next.x  = nx;
            if (y_oob) next.vy = -slot.vy;
            else       next.y  = ny;
`else
            if (x_oob || y_oob) begin
                next.active = 1'b0;
            end else begin
                next.x = nx;
                next.y = ny;
            end
`endif
            next.age = slot.age + AGE_W'(1);
            if (next.age == AGE_W'(LIFE_FRAMES)) next.active = 1'b0;
            // Distances use the post-step integer position, sign-extended to 13 bits
            dx  = {next.x[FIX_W-1], next.x[FIX_W-1:FRAC_W]} - {3'b000, target_x};
            dy  = {next.y[FIX_W-1], next.y[FIX_W-1:FRAC_W]} - {3'b000, target_y};
            adx = dx[FIX_W-FRAC_W] ? -dx : dx;
            ady = dy[FIX_W-FRAC_W] ? -dy : dy;
            if (next.active && (adx <= {3'b000, target_size}) && (ady <= {3'b000, target_size})) begin
                next.active = 1'b0;
                hit         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Per-tank bullet manager: spawns on fire, steps every live slot once per frame.
// Optional edge bounce via BULLET_BOUNCE_EN (inside bullet_step).
module bullet_pool
    import tank_pkg::*;
#(
    parameter int unsigned NUM_BULLETS     = 3,
    parameter int unsigned SPEED           = 2,
    parameter int unsigned SPAWN_OFF       = 12,
    parameter int unsigned LIFE_FRAMES     = 300,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned BULLET_S        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           clear,
    input  logic                           fire,
    input  logic                           tank_alive,
    input  logic [COORD_W-1:0]             tank_x,
    input  logic [COORD_W-1:0]             tank_y,
    input  logic signed [7:0]              sin,
    input  logic signed [7:0]              cos,
    input  logic [COORD_W-1:0]             target_x,
    input  logic [COORD_W-1:0]             target_y,
    input  logic [COORD_W-1:0]             target_size,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
    output logic [COORD_W-1:0]             bullet_s,
    output logic [NUM_BULLETS-1:0]         bullet_active,
    output logic                           hit,
    output logic                           busy
);

    localparam int unsigned IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int unsigned CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    state_t           state;
    state_t           state_next;
    bullet_slot_t     slots      [NUM_BULLETS];
    bullet_slot_t     slots_next [NUM_BULLETS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [CD_W-1:0]  cooldown;
    logic [CD_W-1:0]  cooldown_next;
    logic             pending;
    logic             pending_next;
    logic             hit_flag;
    logic             hit_flag_next;
    logic             spawn_vld;
    logic             spawn_vld_next;
    logic [IDX_W-1:0] spawn_idx;
    logic [IDX_W-1:0] spawn_idx_next;
    logic             hit_next;
    logic             busy_next;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    bullet_slot_t     spawn_slot;
    bullet_slot_t     step_out;
    logic             step_hit;
    q11_4_t           cos_ext;
    q11_4_t           sin_ext;
    q11_4_t           pos_x;
    q11_4_t           pos_y;

    bullet_step #(
        .LIFE_FRAMES (LIFE_FRAMES)
    ) u_step (
        .slot        (slots[idx]),
        .x_min       (COORD_W'(X_MIN)),
        .x_max       (COORD_W'(X_MAX)),
        .y_min       (COORD_W'(Y_MIN)),
        .y_max       (COORD_W'(Y_MAX)),
        .target_x    (target_x),
        .target_y    (target_y),
        .target_size (target_size),
        .next        (step_out),
        .hit         (step_hit)
    );

    // Muzzle position and launch velocity from the current heading
    always_comb begin : spawn_calc
        cos_ext          = {{(FIX_W-8){cos[7]}}, cos};
        sin_ext          = {{(FIX_W-8){sin[7]}}, sin};
        pos_x            = $signed({{(FIX_W-COORD_W){1'b0}}, tank_x})
                         + ((cos_ext * $signed(FIX_W'(SPAWN_OFF))) >>> FRAC_W);
        pos_y            = $signed({{(FIX_W-COORD_W){1'b0}}, tank_y})
                         + ((sin_ext * $signed(FIX_W'(SPAWN_OFF))) >>> FRAC_W);
        spawn_slot        = '0;
        spawn_slot.x      = pos_x <<< FRAC_W;
        spawn_slot.y      = pos_y <<< FRAC_W;
        spawn_slot.vx     = cos_ext * $signed(FIX_W'(SPEED));
        spawn_slot.vy     = sin_ext * $signed(FIX_W'(SPEED));
        spawn_slot.active = 1'b1;
    end

    always_comb begin : next_state
        state_next     = state;
        idx_next       = idx;
        cooldown_next  = cooldown;
        pending_next   = pending | (fire & tank_alive);
        hit_flag_next  = hit_flag;
        spawn_vld_next = spawn_vld;
        spawn_idx_next = spawn_idx;
        slots_next     = slots;
        free_found     = 1'b0;
        free_idx       = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!slots[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        case (state)
            ST_IDLE: begin
                idx_next = '0;
                if (frame_tick) state_next = ST_SPAWN;
            end
            ST_SPAWN: begin
                spawn_vld_next = 1'b0;
                if (pending && (cooldown == '0) && free_found) begin
                    slots_next[free_idx] = spawn_slot;
                    cooldown_next        = CD_W'(COOLDOWN_FRAMES);
                    spawn_vld_next       = 1'b1;
                    spawn_idx_next       = free_idx;
                end else if (cooldown != '0) begin
                    cooldown_next = cooldown - CD_W'(1);
                end
                // The frame's request is consumed; only a fire arriving this cycle survives
                pending_next = fire & tank_alive;
                idx_next     = '0;
                state_next   = ST_STEP;
            end
            ST_STEP: begin
                if (!(spawn_vld && (spawn_idx == idx))) begin
                    slots_next[idx] = step_out;
                    hit_flag_next   = hit_flag | step_hit;
                end
                if (idx == IDX_W'(NUM_BULLETS - 1)) state_next = ST_DONE;
                else                                idx_next   = idx + IDX_W'(1);
            end
            ST_DONE: begin
                hit_flag_next = 1'b0;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (clear) begin
            for (int i = 0; i < NUM_BULLETS; i++) slots_next[i].active = 1'b0;
            state_next     = ST_IDLE;
            idx_next       = '0;
            cooldown_next  = '0;
            pending_next   = 1'b0;
            hit_flag_next  = 1'b0;
            spawn_vld_next = 1'b0;
        end

        busy_next = (state_next != ST_IDLE);
        hit_next  = (state_next == ST_DONE) && hit_flag_next;
    end

    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cooldown  <= '0;
            pending   <= 1'b0;
            hit_flag  <= 1'b0;
            spawn_vld <= 1'b0;
            spawn_idx <= '0;
            hit       <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) slots[i] <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            cooldown  <= cooldown_next;
            pending   <= pending_next;
            hit_flag  <= hit_flag_next;
            spawn_vld <= spawn_vld_next;
            spawn_idx <= spawn_idx_next;
            hit       <= hit_next;
            busy      <= busy_next;
            for (int i = 0; i < NUM_BULLETS; i++) slots[i] <= slots_next[i];
        end
    end

    always_comb begin : slot_outputs
        bullet_x      = '0;
        bullet_y      = '0;
        bullet_active = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bullet_x[i*COORD_W +: COORD_W] = slots[i].x[COORD_W+FRAC_W-1:FRAC_W];
            bullet_y[i*COORD_W +: COORD_W] = slots[i].y[COORD_W+FRAC_W-1:FRAC_W];
            bullet_active[i]               = slots[i].active;
        end
    end

    assign bullet_s = COORD_W'(BULLET_S);

endmodule

// File: tb/tb_bullet_pool.sv
// Randomized and directed bench for bullet_pool against a frame-level reference model.
// Honours BULLET_BOUNCE_EN in the model when the same macro is defined for the build.
module tb_bullet_pool;

    localparam int NB        = 3;
    localparam int SPEED     = 2;
    localparam int SPAWN_OFF = 12;
    localparam int LIFE      = 300;
    localparam int COOLDOWN  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_tick;
    logic            clear;
    logic            fire;
    logic            tank_alive;
    logic [9:0]      tank_x;
    logic [9:0]      tank_y;
    logic signed [7:0] sin;
    logic signed [7:0] cos;
    logic [9:0]      target_x;
    logic [9:0]      target_y;
    logic [9:0]      target_size;
    logic [NB*10-1:0] bullet_x;
    logic [NB*10-1:0] bullet_y;
    logic [9:0]      bullet_s;
    logic [NB-1:0]   bullet_active;
    logic            hit;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;
    int last_hits;

    // Reference model state: positions/velocities in sixteenths of a pixel
    int      m_x [NB];
    int      m_y [NB];
    int      m_vx[NB];
    int      m_vy[NB];
    int      m_age[NB];
    bit [NB-1:0] m_act;
    int      m_cool;
    bit      m_pend;

    bullet_pool dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .clear         (clear),
        .fire          (fire),
        .tank_alive    (tank_alive),
        .tank_x        (tank_x),
        .tank_y        (tank_y),
        .sin           (sin),
        .cos           (cos),
        .target_x      (target_x),
        .target_y      (target_y),
        .target_size   (target_size),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_s      (bullet_s),
        .bullet_active (bullet_active),
        .hit           (hit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit off_field(input int pix, input int lo, input int hi);
        return (pix < lo) || (pix > hi);
    endfunction

    task automatic model_reset();
        m_act  = '0;
        m_cool = 0;
        m_pend = 0;
    endtask

    // One whole frame of game rules, applied to the model
    task automatic model_frame(output int exp_hit);
        int spawned;
        int c;
        int s;
        int nx;
        int ny;
        bit xo;
        bit yo;
        spawned = -1;
        exp_hit = 0;
        c = int'(cos);
        s = int'(sin);
        if (m_pend && m_cool == 0) begin
            for (int i = 0; i < NB; i++) begin
                if (!m_act[i] && spawned < 0) begin
                    spawned  = i;
                    m_x[i]   = (int'(tank_x) + ((c * SPAWN_OFF) >>> 4)) * 16;
                    m_y[i]   = (int'(tank_y) + ((s * SPAWN_OFF) >>> 4)) * 16;
                    m_vx[i]  = c * SPEED;
                    m_vy[i]  = s * SPEED;
                    m_age[i] = 0;
                    m_act[i] = 1'b1;
                end
            end
        end
        if (spawned >= 0)    m_cool = COOLDOWN;
        else if (m_cool > 0) m_cool--;
        m_pend = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] && i != spawned) begin
                nx = m_x[i] + m_vx[i];
                ny = m_y[i] + m_vy[i];
                xo = off_field(nx >>> 4, 0, 639);
                yo = off_field(ny >>> 4, 0, 479);
`ifdef BULLET_BOUNCE_EN
                if (xo) m_vx[i] = -m_vx[i]; else m_x[i] = nx;
                if (yo) m_vy[i] = -m_vy[i]; else m_y[i] = ny;
`else
                if (xo || yo) begin
                    m_act[i] = 1'b0;
                    continue;
                end
                m_x[i] = nx;
                m_y[i] = ny;
`endif
                m_age[i]++;
                if (m_age[i] == LIFE) m_act[i] = 1'b0;
                if (m_act[i] && iabs((m_x[i] >>> 4) - int'(target_x)) <= int'(target_size)
                             && iabs((m_y[i] >>> 4) - int'(target_y)) <= int'(target_size)) begin
                    m_act[i] = 1'b0;
                    exp_hit  = 1;
                end
            end
        end
    endtask

    task automatic compare_state();
        chk("active", 32'(bullet_active), 32'(m_act));
        for (int i = 0; i < NB; i++) begin
            if (m_act[i]) begin
                chk($sformatf("x_slot%0d", i), 32'(bullet_x[i*10 +: 10]), 32'((m_x[i] >>> 4) & 1023));
                chk($sformatf("y_slot%0d", i), 32'(bullet_y[i*10 +: 10]), 32'((m_y[i] >>> 4) & 1023));
            end
        end
    endtask

    task automatic do_fire();
        @(negedge clk);
        fire = 1'b1;
        if (tank_alive) m_pend = 1;
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        chk("clear_active", 32'(bullet_active), 0);
    endtask

    // Tick one frame, count hit pulses while busy, then compare against the model
    task automatic run_frame(input bit extra_tick);
        int n;
        int exp_hit;
        model_frame(exp_hit);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        n = 0;
        last_hits = 0;
        while (busy && n < 20) begin
            if (hit) last_hits++;
            frame_tick = (extra_tick && n == 2);
            @(negedge clk);
            n++;
        end
        frame_tick = 1'b0;
        chk("frame_len", n, NB + 2);
        chk("hit_pulses", last_hits, exp_hit);
        compare_state();
    endtask

    task automatic run_frames(input int count);
        for (int k = 0; k < count; k++) run_frame(1'b0);
    endtask

    task automatic aim(input int tx, input int ty, input int c, input int s);
        tank_x = 10'(tx);
        tank_y = 10'(ty);
        cos    = 8'(c);
        sin    = 8'(s);
    endtask

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        clear       = 1'b0;
        fire        = 1'b0;
        tank_alive  = 1'b1;
        tank_x      = '0;
        tank_y      = '0;
        sin         = '0;
        cos         = '0;
        target_x    = 10'd600;
        target_y    = 10'd20;
        target_size = 10'd1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(bullet_active), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bx", 32'(bullet_x), 0);
        chk("rst_by", 32'(bullet_y), 0);
        chk("bullet_s", 32'(bullet_s), 2);
        rst = 1'b0;
        @(negedge clk);

        // Straight shot to the right
        aim(100, 200, 16, 0);
        do_fire();
        run_frame(1'b0);
        chk("t2_x0", 32'(bullet_x[9:0]), 112);
        chk("t2_y0", 32'(bullet_y[9:0]), 200);
        run_frame(1'b0);
        chk("t2_x1", 32'(bullet_x[9:0]), 114);
        run_frame(1'b0);
        chk("t2_x2", 32'(bullet_x[9:0]), 116);

        // Right-edge behaviour
        do_clear();
        aim(626, 200, 16, 0);
        do_fire();
        run_frame(1'b0);
        chk("t3_spawn", 32'(bullet_x[9:0]), 638);
        run_frame(1'b0);
`ifdef BULLET_BOUNCE_EN
        chk("t3_hold", 32'(bullet_x[9:0]), 638);
        run_frame(1'b0);
        chk("t3_back", 32'(bullet_x[9:0]), 636);
`else
        chk("t3_gone", 32'(bullet_active[0]), 0);
`endif

        // Lifetime
        do_clear();
        aim(320, 240, 0, 0);
        do_fire();
        run_frame(1'b0);
        run_frames(LIFE - 1);
        chk("t4_alive_299", 32'(bullet_active[0]), 1);
        run_frame(1'b0);
        chk("t4_dead_300", 32'(bullet_active[0]), 0);

        // Hit on one slot leaves a bystander slot alone
        do_clear();
        target_x = 10'd116;
        target_y = 10'd200;
        target_size = 10'd8;
        aim(300, 300, 0, 0);
        do_fire();
        run_frame(1'b0);
        run_frames(9);
        aim(100, 200, 16, 0);
        do_fire();
        run_frame(1'b0);
        chk("t5_spawned", 32'(bullet_active), 3);
        run_frame(1'b0);
        chk("t5_hit_once", last_hits, 1);
        chk("t5_active", 32'(bullet_active), 1);

        // Pool exhaustion, cooldown, clear
        do_clear();
        target_x = 10'd600;
        target_y = 10'd20;
        target_size = 10'd1;
        aim(320, 240, 0, 0);
        for (int k = 0; k < 4; k++) begin
            do_fire();
            run_frame(1'b0);
            run_frames(9);
        end
        chk("t6_full", 32'(bullet_active), 7);
        do_clear();
        do_fire();
        run_frame(1'b0);
        run_frames(2);
        do_fire();
        run_frame(1'b0);
        chk("t6_cooldown", 32'(bullet_active), 1);
        do_clear();

        // Randomized play
        for (int f = 0; f < 250; f++) begin
            aim($urandom_range(0, 639), $urandom_range(0, 479),
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            target_x    = 10'($urandom_range(0, 639));
            target_y    = 10'($urandom_range(0, 479));
            target_size = 10'($urandom_range(0, 40));
            tank_alive  = ($urandom_range(0, 3) != 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) do_fire();
            if ($urandom_range(0, 39) == 0) do_clear();
            run_frame($urandom_range(0, 9) == 0);
        end
        tank_alive = 1'b1;

        // Reset in the middle of the step phase
        aim(200, 200, 16, 16);
        do_fire();
        run_frame(1'b0);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_active", 32'(bullet_active), 0);
        chk("midrst_hit", 32'(hit), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_bx", 32'(bullet_x), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);
        run_frame(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
Per-tank bullet manager that sits directly upstream of the colour mapper. It owns NUM_BULLETS bullet slots and spawns a bullet from the tank's muzzle on a fire request. Once per frame it moves every live bullet along its heading, bounces bullets off the playfield edges, ages them out, and checks each one against the opposing tank. Its outputs are the per-slot bullet X/Y, size and active flag that the colour mapper draws, plus a hit pulse to game control.

Parameters:
NUM_BULLETS, 3, bullet slots per tank
SPEED, 2, integer pixels per frame at unit heading
SPAWN_OFF, 12, muzzle distance from tank centre in pixels
LIFE_FRAMES, 300, frames a bullet lives
COOLDOWN_FRAMES, 8, minimum frames between accepted shots
BULLET_S, 2, bullet half-size driven on bullet_s
X_MIN / X_MAX, 0 / 639, playfield horizontal bounds, inclusive
Y_MIN / Y_MAX, 0 / 479, playfield vertical bounds, inclusive

Ports:
CLK  in  1  system clock
Reset  in  1  asynchronous, active-high
frame_tick  in  1  one-cycle strobe at vertical-blank start
clear  in  1  synchronous round reset
fire  in  1  one-cycle fire request
tank_alive  in  1  fire is ignored when 0
tank_x, tank_y  in  10  shooter centre
sin, cos  in  8  signed Q3.4 heading (16 = 1.0)
target_x, target_y  in  10  opposing tank centre
target_size  in  10  opposing tank half-size
bullet_x, bullet_y  out  NUM_BULLETS*10  packed; slot i occupies bits [10i+9:10i]
bullet_s  out  10  constant BULLET_S
bullet_active  out  NUM_BULLETS  per-slot live flag
hit  out  1  one-cycle pulse when the target is struck
busy  out  1  frame update in progress

Behaviour:
- Reset: all bullet_x, bullet_y, bullet_active, hit, busy, cooldown, age and pending registers are 0. The FSM is in IDLE.
- Internal state per slot: x, y as signed 16-bit Q11.4; vx, vy as signed 16-bit Q11.4; age as a 9-bit counter. bullet_x is x[13:4]; bullet_y is y[13:4].
- fire sets fire_pending when tank_alive=1. Multiple fires before the next frame_tick collapse into one pending request.
- FSM states:
  - IDLE: on frame_tick go to SPAWN; busy goes to 1.
  - SPAWN: if fire_pending=1, cooldown=0 and a free slot exists, load the lowest-index free slot:
    - x = tank_x + (cos*SPAWN_OFF)>>>4; y likewise from sin.
    - vx = sext(cos)*SPEED; vy = sext(sin)*SPEED.
    - age = 0; active = 1; cooldown = COOLDOWN_FRAMES.
    - Else, decrement cooldown if it is nonzero.
    - Clear fire_pending in both cases; a request made while no slot is free or cooldown is nonzero is dropped.
  - STEP: one slot per cycle, idx 0..NUM_BULLETS-1. Inactive slots and the slot spawned this frame are untouched. For every other slot:
    - nx = x+vx, ny = y+vy; compare the integer part of each against the bounds per axis.
    - Out of bounds: apply the edge rule (see Optional Feature).
    - age += 1; when age reaches LIFE_FRAMES, active = 0.
    - Still active and |x_int - target_x| <= target_size and |y_int - target_y| <= target_size: active = 0 and latch hit_flag.
  - DONE: hit = hit_flag for exactly one cycle; clear hit_flag; busy = 0; return to IDLE.
- Latency: a frame_tick at cycle t gives SPAWN at t+1, STEP at t+2..t+1+N, DONE at t+2+N. Outputs are final by t+3+N.
- frame_tick while busy is ignored.
- clear has priority over everything. It deactivates all slots, zeroes cooldown, pending and hit_flag, and forces IDLE on the next edge.
- Reset mid-update returns to the full reset state immediately.
- Both axes out of bounds in the same step: both axes take the edge rule independently.

Optional Feature:
BULLET_BOUNCE_EN
- Defined: an out-of-bounds axis keeps its old coordinate and negates its velocity component; the other axis advances normally.
- Undefined: any out-of-bounds step deactivates the slot, with no hit check for that slot on that step.

Decomposition:
- Shared package tank_pkg holds:
  - the Q11.4 fixed-point typedef;
  - the bullet_slot_t struct (x, y, vx, vy, age, active);
  - the screen-bound constants;
  - the FSM state enum.
- One natural combinational sub-module, bullet_step: takes a slot_t plus bounds and target, and returns the next slot_t plus a hit bit. It is instantiated once and time-multiplexed across slots by idx.

Test Plan:
1. Reset asserted mid-STEP -> all bullet_active=0, hit=0 and busy=0 immediately; FSM is IDLE after release.
2. Tank at (100,200), cos=16, sin=0, fire then frame_tick -> slot0 active at (112,200); after the next tick x=114; after another tick x=116.
3. Slot at x=638 with vx=+2.0 -> BULLET_BOUNCE_EN: next frame x=638, vx=-2.0, then x=636. Without the macro: slot0 inactive after that frame.
4. Spawn, then 299 ticks -> still active; on the 300th tick -> inactive.
5. Bullet reaches (114,200) with target (116,200) and size 8 -> hit high for exactly one cycle in DONE; slot inactive; other slots unaffected.
6. Four fires spaced 10 frames apart -> slots 0, 1, 2 fill and the 4th is dropped. A fire 3 frames after an accepted shot -> dropped by cooldown. clear -> all slots inactive within one cycle.
